// File: rtl/fetch_pipeline_controller_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_pipeline_controller_pkg                                |
// | Description : Shared state encodings and flush-vector layout for the fetch |
// |               pipeline controller.                                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pipeline_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    localparam int c_FLUSH_W     = 3;
    localparam int c_FLUSH_IFID  = 0;
    localparam int c_FLUSH_IDEX  = 1;
    localparam int c_FLUSH_EXMEM = 2;

    localparam logic [c_FLUSH_W-1:0] c_FLUSH_NONE   = 3'b000;
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_ALL    = 3'b111;
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_BUBBLE = 3'(1 << c_FLUSH_IDEX);

endpackage

`default_nettype wire

// File: rtl/fetch_pipeline_controller_if.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_pipeline_controller_if                                 |
// | Description : Hazard inputs and PC / pipeline-register controls exchanged  |
// |               between the controller (master) and the datapath (slave).    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_pipeline_controller_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              BranchResult;
    logic [ADDR_W-1:0] BranchTarget;
    logic              IDEX_MemRead;
    logic [4:0]        IDEX_Rt;
    logic [4:0]        IFID_Rs;
    logic [4:0]        IFID_Rt;
    logic              IFID_UsesRt;
    logic              Halt;
    logic              Resume;

    logic              PCWrite;
    logic              PCSrc;
    logic [ADDR_W-1:0] PCTarget;
    logic              IFIDWrite;
    logic              IFIDFlush;
    logic              IDEXFlush;
    logic              EXMEMFlush;
    logic              Halted;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  RedirectCount;

    modport master (
        input  BranchResult, BranchTarget, IDEX_MemRead, IDEX_Rt,
               IFID_Rs, IFID_Rt, IFID_UsesRt, Halt, Resume,
        output PCWrite, PCSrc, PCTarget, IFIDWrite, IFIDFlush, IDEXFlush,
               EXMEMFlush, Halted, StallCount, RedirectCount
    );

    modport slave (
        output BranchResult, BranchTarget, IDEX_MemRead, IDEX_Rt,
               IFID_Rs, IFID_Rt, IFID_UsesRt, Halt, Resume,
        input  PCWrite, PCSrc, PCTarget, IFIDWrite, IFIDFlush, IDEXFlush,
               EXMEMFlush, Halted, StallCount, RedirectCount
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pipeline_controller_load_use_detect.sv
// +----------------------------------------------------------------------------+
// | Module      : load_use_detect                                              |
// | Description : Flags a load in ID/EX whose destination is read by the       |
// |               instruction currently in IF/ID.                              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_use_detect
    import fetch_pipeline_controller_pkg::*;
(
    input  wire logic       i_idex_mem_read,
    input  wire logic [4:0] i_idex_rt,
    input  wire logic [4:0] i_ifid_rs,
    input  wire logic [4:0] i_ifid_rt,
    input  wire logic       i_ifid_uses_rt,
    output logic            o_hazard
);
    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_rs_match = (i_idex_rt == i_ifid_rs);
        w_rt_match = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
        // Register zero is hard-wired, so a load targeting it never creates a dependency.
        o_hazard   = i_idex_mem_read && (i_idex_rt != c_REG_ZERO) && (w_rs_match || w_rt_match);
    end
endmodule

`default_nettype wire

// File: rtl/fetch_pipeline_controller.sv
// +----------------------------------------------------------------------------+
// | Module      : fetch_pipeline_controller                                    |
// | Description : Drives PC load/select and pipeline flushes; resolves         |
// |               load-use stalls, branch redirects and halt/resume.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_pipeline_controller
    import fetch_pipeline_controller_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  wire logic                   Clk,
    input  wire logic                   Rst,
    fetch_pipeline_controller_if.master bus
);
    localparam logic [3:0] c_STALL_RELOAD = 4'(STALL_CYCLES - 1);

    state_e             state_q,       state_d;
    logic [3:0]         stall_left_q,  stall_left_d;
    logic [CNT_W-1:0]   stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]   redir_cnt_q,   redir_cnt_d;

    logic               w_hazard;
    logic               w_pc_write;
    logic               w_pc_src;
    logic [ADDR_W-1:0]  w_pc_target;
    logic               w_ifid_write;
    logic [c_FLUSH_W-1:0] w_flush;
    logic [CNT_W-1:0]   w_stall_inc;
    logic [CNT_W-1:0]   w_redir_inc;

    load_use_detect u_load_use_detect (
        .i_idex_mem_read (bus.IDEX_MemRead),
        .i_idex_rt       (bus.IDEX_Rt),
        .i_ifid_rs       (bus.IFID_Rs),
        .i_ifid_rt       (bus.IFID_Rt),
        .i_ifid_uses_rt  (bus.IFID_UsesRt),
        .o_hazard        (w_hazard)
    );

    always_comb begin
        w_stall_inc = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        w_redir_inc = (redir_cnt_q == {CNT_W{1'b1}}) ? redir_cnt_q : redir_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        stall_cnt_d  = stall_cnt_q;
        redir_cnt_d  = redir_cnt_q;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_pc_target  = {ADDR_W{1'b0}};
        w_ifid_write = 1'b0;
        w_flush      = c_FLUSH_NONE;

        if (!Rst) begin
            w_flush = c_FLUSH_ALL;
        end else if (bus.BranchResult) begin
            w_pc_src     = 1'b1;
            w_pc_target  = bus.BranchTarget;
            w_pc_write   = 1'b1;
            w_flush      = c_FLUSH_ALL;
            redir_cnt_d  = w_redir_inc;
            state_d      = ST_RUN;
            stall_left_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.Halt) begin
                        // Fetch freezes in the same cycle the halt request is seen.
                        w_flush = c_FLUSH_BUBBLE;
                        state_d = ST_HALT;
                    end else if (w_hazard) begin
                        w_flush     = c_FLUSH_BUBBLE;
                        stall_cnt_d = w_stall_inc;
                        if (STALL_CYCLES > 1) begin
                            state_d      = ST_STALL;
                            stall_left_d = c_STALL_RELOAD;
                        end
                    end else begin
                        w_pc_write   = 1'b1;
                        w_ifid_write = 1'b1;
                    end
                end
                ST_STALL: begin
                    w_flush = c_FLUSH_BUBBLE;
                    if (bus.Halt) begin
                        state_d      = ST_HALT;
                        stall_left_d = 4'd0;
                    end else begin
                        stall_cnt_d  = w_stall_inc;
                        stall_left_d = stall_left_q - 4'd1;
                        if (stall_left_q == 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    w_flush = c_FLUSH_BUBBLE;
                    if (bus.Resume || !bus.Halt) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d      = ST_RUN;
                    stall_left_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= ST_RUN;
            stall_left_q <= 4'd0;
            stall_cnt_q  <= {CNT_W{1'b0}};
            redir_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            stall_cnt_q  <= stall_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
        end
    end

    always_comb begin
        bus.PCWrite       = w_pc_write;
        bus.PCSrc         = w_pc_src;
        bus.PCTarget      = w_pc_target;
        bus.IFIDWrite     = w_ifid_write;
        bus.IFIDFlush     = w_flush[c_FLUSH_IFID];
        bus.IDEXFlush     = w_flush[c_FLUSH_IDEX];
        bus.EXMEMFlush    = w_flush[c_FLUSH_EXMEM];
        bus.Halted        = Rst && (state_q == ST_HALT);
        bus.StallCount    = stall_cnt_q;
        bus.RedirectCount = redir_cnt_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_fetch_pipeline_controller.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_pipeline_controller                                 |
// | Description : Directed self-checking bench; one single-bubble 32-bit build |
// |               and one 3-bubble build with 4-bit counters.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_pipeline_controller;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_pipeline_controller_if #(.ADDR_W(32), .CNT_W(32)) bus_a ();
    fetch_pipeline_controller_if #(.ADDR_W(32), .CNT_W(4))  bus_b ();

    fetch_pipeline_controller #(.ADDR_W(32), .STALL_CYCLES(1), .CNT_W(32)) u_dut_a (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus_a)
    );

    fetch_pipeline_controller #(.ADDR_W(32), .STALL_CYCLES(3), .CNT_W(4)) u_dut_b (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        bus_a.BranchResult = 1'b0; bus_a.BranchTarget = 32'h0;
        bus_a.IDEX_MemRead = 1'b0; bus_a.IDEX_Rt = 5'd0;
        bus_a.IFID_Rs = 5'd0; bus_a.IFID_Rt = 5'd0; bus_a.IFID_UsesRt = 1'b0;
        bus_a.Halt = 1'b0; bus_a.Resume = 1'b0;
    endtask

    task automatic clear_b();
        bus_b.BranchResult = 1'b0; bus_b.BranchTarget = 32'h0;
        bus_b.IDEX_MemRead = 1'b0; bus_b.IDEX_Rt = 5'd0;
        bus_b.IFID_Rs = 5'd0; bus_b.IFID_Rt = 5'd0; bus_b.IFID_UsesRt = 1'b0;
        bus_b.Halt = 1'b0; bus_b.Resume = 1'b0;
    endtask

    task automatic randomize_a();
        bus_a.BranchResult = 1'($urandom); bus_a.BranchTarget = $urandom;
        bus_a.IDEX_MemRead = 1'($urandom); bus_a.IDEX_Rt = 5'($urandom);
        bus_a.IFID_Rs = 5'($urandom); bus_a.IFID_Rt = 5'($urandom);
        bus_a.IFID_UsesRt = 1'($urandom); bus_a.Halt = 1'($urandom); bus_a.Resume = 1'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_a();
        clear_b();

        // Reset held two cycles with random inputs on A.
        for (int i = 0; i < 2; i++) begin
            randomize_a();
            #2;
            check_eq("rst_pcwrite", 64'(bus_a.PCWrite), 64'd0);
            check_eq("rst_flushes", 64'({bus_a.IFIDFlush, bus_a.IDEXFlush, bus_a.EXMEMFlush}), 64'h7);
            check_eq("rst_pcsrc_tgt", 64'({bus_a.PCSrc, bus_a.PCTarget}), 64'd0);
            check_eq("rst_halted", 64'(bus_a.Halted), 64'd0);
            tick();
        end
        check_eq("rst_cnt_a", 64'({bus_a.StallCount, bus_a.RedirectCount}), 64'd0);
        check_eq("rst_cnt_b", 64'({bus_b.StallCount, bus_b.RedirectCount}), 64'd0);

        clear_a();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_pcwrite", 64'(bus_a.PCWrite), 64'd1);
        check_eq("post_rst_flushes", 64'({bus_a.IFIDFlush, bus_a.IDEXFlush, bus_a.EXMEMFlush}), 64'h0);
        tick();

        // Single-bubble load-use hazard on Rs.
        bus_a.IDEX_MemRead = 1'b1; bus_a.IDEX_Rt = 5'd5; bus_a.IFID_Rs = 5'd5;
        #1;
        check_eq("hz_pcwrite", 64'(bus_a.PCWrite), 64'd0);
        check_eq("hz_ifidwrite", 64'(bus_a.IFIDWrite), 64'd0);
        check_eq("hz_flushes", 64'({bus_a.IFIDFlush, bus_a.IDEXFlush, bus_a.EXMEMFlush}), 64'h2);
        tick();
        clear_a();
        #1;
        check_eq("hz_stallcnt", 64'(bus_a.StallCount), 64'd1);
        check_eq("hz_released", 64'(bus_a.PCWrite), 64'd1);

        // Load to r0 never stalls.
        bus_a.IDEX_MemRead = 1'b1; bus_a.IDEX_Rt = 5'd0; bus_a.IFID_Rs = 5'd0;
        #1;
        check_eq("r0_pcwrite", 64'(bus_a.PCWrite), 64'd1);
        tick();
        check_eq("r0_stallcnt", 64'(bus_a.StallCount), 64'd1);

        // Rt match only counts when the instruction reads Rt.
        bus_a.IDEX_Rt = 5'd9; bus_a.IFID_Rs = 5'd3; bus_a.IFID_Rt = 5'd9; bus_a.IFID_UsesRt = 1'b0;
        #1;
        check_eq("rt_unused_pcwrite", 64'(bus_a.PCWrite), 64'd1);
        bus_a.IFID_UsesRt = 1'b1;
        #1;
        check_eq("rt_used_pcwrite", 64'(bus_a.PCWrite), 64'd0);
        tick();
        clear_a();
        #1;
        check_eq("rt_stallcnt", 64'(bus_a.StallCount), 64'd2);

        // Branch and hazard together: redirect wins.
        bus_a.IDEX_MemRead = 1'b1; bus_a.IDEX_Rt = 5'd7; bus_a.IFID_Rs = 5'd7;
        bus_a.BranchResult = 1'b1; bus_a.BranchTarget = 32'h0000_1234;
        #1;
        check_eq("br_hz_pcsrc", 64'(bus_a.PCSrc), 64'd1);
        check_eq("br_hz_target", 64'(bus_a.PCTarget), 64'h1234);
        check_eq("br_hz_pcwrite", 64'(bus_a.PCWrite), 64'd1);
        check_eq("br_hz_flushes", 64'({bus_a.IFIDFlush, bus_a.IDEXFlush, bus_a.EXMEMFlush}), 64'h7);
        tick();
        clear_a();
        #1;
        check_eq("br_hz_stallcnt", 64'(bus_a.StallCount), 64'd2);
        check_eq("br_hz_redircnt", 64'(bus_a.RedirectCount), 64'd1);
        check_eq("br_hz_target_clr", 64'({bus_a.PCSrc, bus_a.PCTarget}), 64'd0);

        // Halt held five cycles, then a Resume pulse.
        bus_a.Halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("halt_pcwrite", 64'(bus_a.PCWrite), 64'd0);
            if (i > 0) check_eq("halt_halted", 64'(bus_a.Halted), 64'd1);
            tick();
        end
        bus_a.Resume = 1'b1;
        #1;
        check_eq("resume_halted", 64'(bus_a.Halted), 64'd1);
        tick();
        bus_a.Resume = 1'b0; bus_a.Halt = 1'b0;
        #1;
        check_eq("resumed_halted", 64'(bus_a.Halted), 64'd0);
        check_eq("resumed_pcwrite", 64'(bus_a.PCWrite), 64'd1);

        // Level release: Halt low for one halted cycle returns to RUN.
        bus_a.Halt = 1'b1;
        tick();
        bus_a.Halt = 1'b0;
        #1;
        check_eq("lvl_halted", 64'(bus_a.Halted), 64'd1);
        check_eq("lvl_pcwrite", 64'(bus_a.PCWrite), 64'd0);
        tick();
        check_eq("lvl_released", 64'({bus_a.Halted, bus_a.PCWrite}), 64'd1);

        // Resume outside HALT is ignored.
        bus_a.Resume = 1'b1;
        tick();
        bus_a.Resume = 1'b0;
        #1;
        check_eq("stray_resume", 64'({bus_a.Halted, bus_a.PCWrite}), 64'd1);

        // Build B: 3-bubble stall aborted by a branch in the second STALL cycle.
        bus_b.IDEX_MemRead = 1'b1; bus_b.IDEX_Rt = 5'd3; bus_b.IFID_Rs = 5'd3;
        #1;
        check_eq("b_hz_pcwrite", 64'(bus_b.PCWrite), 64'd0);
        tick();
        clear_b();
        #1;
        check_eq("b_stall1_pcwrite", 64'(bus_b.PCWrite), 64'd0);
        check_eq("b_stall1_idexflush", 64'(bus_b.IDEXFlush), 64'd1);
        tick();
        bus_b.BranchResult = 1'b1; bus_b.BranchTarget = 32'h0000_0040;
        #1;
        check_eq("b_br_pcsrc", 64'(bus_b.PCSrc), 64'd1);
        check_eq("b_br_target", 64'(bus_b.PCTarget), 64'h40);
        check_eq("b_br_flushes", 64'({bus_b.IFIDFlush, bus_b.IDEXFlush, bus_b.EXMEMFlush}), 64'h7);
        tick();
        clear_b();
        #1;
        check_eq("b_br_stallcnt", 64'(bus_b.StallCount), 64'd2);
        check_eq("b_br_redircnt", 64'(bus_b.RedirectCount), 64'd1);
        check_eq("b_br_run", 64'(bus_b.PCWrite), 64'd1);

        // Build B: 20 hazard cycles saturate the 4-bit stall counter.
        bus_b.IDEX_MemRead = 1'b1; bus_b.IDEX_Rt = 5'd12; bus_b.IFID_Rs = 5'd12;
        for (int i = 0; i < 20; i++) tick();
        check_eq("b_sat", 64'(bus_b.StallCount), 64'hF);
        tick();
        check_eq("b_sat_hold", 64'(bus_b.StallCount), 64'hF);
        clear_b();
        for (int i = 0; i < 4; i++) tick();
        check_eq("b_sat_idle", 64'({bus_b.PCWrite, bus_b.StallCount}), 64'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
